// File: rtl/scan_mux_pkg.sv
// rtl/scan_mux_pkg.sv - shared types and constants for the scan_mux block
// Contents: FSM state enum, mode encodings.

package scan_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_EMIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_mux_if.sv
// rtl/scan_mux_if.sv - output beat interface of scan_mux (valid/ready handshake)
// Signals: out_data (W), out_ch (SEL_W), sel_err, out_valid driven by master;
//          out_ready driven by slave (the consumer).

interface scan_mux_if #(
    parameter int W     = 1,
    parameter int SEL_W = 3
);
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_ch;
    logic             sel_err;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output out_data, out_ch, sel_err, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_ch, sel_err, out_valid,
        output out_ready
    );
endinterface

// File: rtl/scan_mux_mux_n_to_1.sv
// rtl/scan_mux_mux_n_to_1.sv - combinational N_CH x W selector with out-of-range flag
// Ports: data_in (N_CH*W packed, channel k at [k*W +: W]), sel (SEL_W),
//        dout (W, zero when sel is out of range), oor (sel >= N_CH).

module mux_n_to_1 #(
    parameter int N_CH  = 8,
    parameter int W     = 1,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH*W-1:0] data_in,
    input  logic [SEL_W-1:0]  sel,
    output logic [W-1:0]      dout,
    output logic              oor
);

    // No channel matches an out-of-range select, so dout falls back to zero.
    always_comb begin
        dout = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k)) begin
                dout = data_in[k*W +: W];
            end
        end
    end

    assign oor = ({1'b0, sel} >= (SEL_W+1)'(N_CH));

endmodule

// File: rtl/scan_mux.sv
// rtl/scan_mux.sv - N-channel registered mux with manual select and scan sequencer
// Ports: clk, rst (async active-high); data_in (N_CH*W), ch_en (N_CH), mode,
//        sel_in (SEL_W), start, stop; ob (scan_mux_if.master: out_data, out_ch,
//        sel_err, out_valid, out_ready); busy, frame_done.
// Optional build macro: SCAN_MUX_CONT_EN (continuous scanning ended by stop).

module scan_mux
    import scan_mux_pkg::*;
#(
    parameter int  N_CH  = 8,
    parameter int  W     = 1,
    parameter int  DWELL = 1,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH*W-1:0] data_in,
    input  logic [N_CH-1:0]   ch_en,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic              start,
    input  logic              stop,
    scan_mux_if.master        ob,
    output logic              busy,
    output logic              frame_done
);

    localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(N_CH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t           state, state_nxt;
    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;

    logic             slot_free;
    logic [SEL_W-1:0] mux_sel;
    logic [W-1:0]     mux_dout;
    logic             mux_oor;
    logic             chan_on, at_last, dwell_end, wrap;
    logic             load_manual, load_scan, ptr_clr, ptr_inc, cnt_inc;

    assign slot_free = !ob.out_valid || ob.out_ready;
    // Manual select only matters in IDLE; every other state looks at the pointer.
    assign mux_sel   = (state == ST_IDLE) ? sel_in : ptr;
    assign chan_on   = ch_en[ptr];
    assign at_last   = (ptr == LAST_CH);
    assign dwell_end = (cnt == CNT_LAST);

    mux_n_to_1 #(.N_CH(N_CH), .W(W), .SEL_W(SEL_W)) u_mux (
        .data_in (data_in),
        .sel     (mux_sel),
        .dout    (mux_dout),
        .oor     (mux_oor)
    );

`ifdef SCAN_MUX_CONT_EN
    logic stop_flag;

    // stop is sticky for the rest of the frame; a stop in the DONE cycle itself counts.
    assign wrap = !(stop_flag || stop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stop_flag <= 1'b0;
        end else if (state == ST_IDLE) begin
            stop_flag <= 1'b0;
        end else if (stop) begin
            stop_flag <= 1'b1;
        end
    end
`else
    wire unused_stop = stop;
    assign wrap = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (mode == MODE_SCAN && start) state_nxt = ST_DWELL;
            ST_DWELL: begin
                if (!chan_on) begin
                    if (at_last) state_nxt = ST_DONE;
                end else if (dwell_end) begin
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT:  if (slot_free) state_nxt = at_last ? ST_DONE : ST_DWELL;
            ST_DONE:  state_nxt = wrap ? ST_DWELL : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != ST_IDLE);
        frame_done  = (state == ST_DONE);
        load_manual = (state == ST_IDLE) && (mode == MODE_MANUAL) && slot_free;
        load_scan   = (state == ST_EMIT) && slot_free;
        ptr_clr     = ((state == ST_IDLE) && (mode == MODE_SCAN) && start) ||
                      ((state == ST_DONE) && wrap);
        // Disabled channels cost one cycle each and never touch the dwell counter.
        ptr_inc     = ((state == ST_DWELL) && !chan_on && !at_last) ||
                      (load_scan && !at_last);
        cnt_inc     = (state == ST_DWELL) && chan_on && !dwell_end;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr          <= '0;
            cnt          <= '0;
            ob.out_data  <= '0;
            ob.out_ch    <= '0;
            ob.sel_err   <= 1'b0;
            ob.out_valid <= 1'b0;
        end else begin
            if (ptr_clr) begin
                ptr <= '0;
            end else if (ptr_inc) begin
                ptr <= ptr + 1'b1;
            end
            cnt <= cnt_inc ? cnt + 1'b1 : '0;

            if (load_manual) begin
                ob.out_data  <= mux_dout;
                ob.out_ch    <= sel_in;
                ob.sel_err   <= mux_oor;
                ob.out_valid <= 1'b1;
            end else if (load_scan) begin
                ob.out_data  <= mux_dout;
                ob.out_ch    <= ptr;
                ob.sel_err   <= 1'b0;
                ob.out_valid <= 1'b1;
            end else if (slot_free) begin
                ob.out_valid <= 1'b0;
            end
        end
    end

endmodule
